gcbp_subimage_write_ctrl: RTL



---
 rtl/gcbp_subimage_write_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/gcbp_subimage_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gcbp_subimage_write_ctrl
//  Purpose  : Takes the raster pixel stream from video capture, tracks each
//             pixel's frame position and tiles the frame into a
//             GRID_X x GRID_Y array of subimages (one BRAM each). For every
//             accepted pixel it issues a registered one-hot BRAM write
//             enable, the local BRAM address and the pixel data.
//  Ports    : clk, rst_n (synchronous, active-low)
//             pix_valid / pix_sof / pix_data  : input pixel stream
//             bram_wea  : one-hot write enable, bit n = BRAM n
//             bram_addr : local write address shared by all BRAMs
//             bram_din  : write data shared by all BRAMs
//             frame_done: pulse with the last pixel's write
//             sync_err  : pulse when SOF restarts a partly written frame
//             busy      : high while a frame is in progress
//  Options  : GCBP_PINGPONG_EN - bram_addr MSB becomes a bank bit that
//             toggles after every completed frame.
//  Revision : 1.0 - initial release
// ============================================================================
module gcbp_subimage_write_ctrl #(
  parameter int GRID_X = 4,
  parameter int GRID_Y = 4,
  parameter int SUB_W  = 160,
  parameter int SUB_H  = 120,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_valid,
  input  logic                     pix_sof,
  input  logic [DATA_W-1:0]        pix_data,
  output logic [GRID_X*GRID_Y-1:0] bram_wea,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [DATA_W-1:0]        bram_din,
  output logic                     frame_done,
  output logic                     sync_err,
  output logic                     busy
);

  localparam int c_N     = GRID_X * GRID_Y;
  localparam int c_X_W   = $clog2(SUB_W);
  localparam int c_Y_W   = $clog2(SUB_H);
  localparam int c_HX_W  = (GRID_X > 1) ? $clog2(GRID_X) : 1;
  localparam int c_VY_W  = (GRID_Y > 1) ? $clog2(GRID_Y) : 1;
  localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_LOC_W = $clog2(SUB_W * SUB_H);

  typedef enum logic [0:0] {
    S_WAIT_SOF = 1'b0,
    S_ACTIVE   = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [c_X_W-1:0]   r_sub_x,     w_sub_x_nxt;
  logic [c_HX_W-1:0]  r_hori,      w_hori_nxt;
  logic [c_Y_W-1:0]   r_sub_y,     w_sub_y_nxt;
  logic [c_VY_W-1:0]  r_vert,      w_vert_nxt;
  // Running products sub_y*SUB_W and vert_cnt*GRID_X, kept incrementally so
  // the per-pixel path only needs adders.
  logic [c_LOC_W-1:0] r_row_base,  w_row_base_nxt;
  logic [c_IDX_W-1:0] r_vert_base, w_vert_base_nxt;

  logic               w_accept, w_restart, w_sync_err, w_last;
  logic               w_end_x, w_end_h, w_end_y, w_end_v;
  logic [c_X_W-1:0]   w_px;
  logic [c_HX_W-1:0]  w_ph;
  logic [c_Y_W-1:0]   w_py;
  logic [c_VY_W-1:0]  w_pv;
  logic [c_LOC_W-1:0] w_prow_base, w_loc;
  logic [c_IDX_W-1:0] w_pvert_base, w_idx;
  logic [ADDR_W-1:0]  w_addr;

`ifdef GCBP_PINGPONG_EN
  logic r_bank;
`endif

  always_comb begin
    w_restart = pix_valid && pix_sof;
    w_accept  = pix_valid && (pix_sof || (r_state == S_ACTIVE));

    // An SOF pixel always lands at (0,0), whatever the counters hold.
    w_px         = w_restart ? '0 : r_sub_x;
    w_ph         = w_restart ? '0 : r_hori;
    w_py         = w_restart ? '0 : r_sub_y;
    w_pv         = w_restart ? '0 : r_vert;
    w_prow_base  = w_restart ? '0 : r_row_base;
    w_pvert_base = w_restart ? '0 : r_vert_base;

    w_sync_err = w_restart && (r_state == S_ACTIVE) &&
                 ((r_sub_x != '0) || (r_hori != '0) ||
                  (r_sub_y != '0) || (r_vert != '0));

    w_end_x = (w_px == c_X_W'(SUB_W - 1));
    w_end_h = (w_ph == c_HX_W'(GRID_X - 1));
    w_end_y = (w_py == c_Y_W'(SUB_H - 1));
    w_end_v = (w_pv == c_VY_W'(GRID_Y - 1));
    w_last  = w_end_x && w_end_h && w_end_y && w_end_v;

    w_loc = w_prow_base + c_LOC_W'(w_px);
    w_idx = w_pvert_base + c_IDX_W'(w_ph);

    w_addr = '0;
    w_addr[c_LOC_W-1:0] = w_loc;
`ifdef GCBP_PINGPONG_EN
    w_addr[ADDR_W-1] = r_bank;
`endif

    w_state_nxt     = r_state;
    w_sub_x_nxt     = r_sub_x;
    w_hori_nxt      = r_hori;
    w_sub_y_nxt     = r_sub_y;
    w_vert_nxt      = r_vert;
    w_row_base_nxt  = r_row_base;
    w_vert_base_nxt = r_vert_base;

    if (w_accept) begin
      // Advance from the position just written; the last pixel of the
      // frame wraps every counter back to zero on its own.
      w_state_nxt     = w_last ? S_WAIT_SOF : S_ACTIVE;
      w_sub_x_nxt     = w_end_x ? '0 : w_px + c_X_W'(1);
      w_hori_nxt      = w_ph;
      w_sub_y_nxt     = w_py;
      w_vert_nxt      = w_pv;
      w_row_base_nxt  = w_prow_base;
      w_vert_base_nxt = w_pvert_base;
      if (w_end_x) begin
        w_hori_nxt = w_end_h ? '0 : w_ph + c_HX_W'(1);
        if (w_end_h) begin
          w_sub_y_nxt    = w_end_y ? '0 : w_py + c_Y_W'(1);
          w_row_base_nxt = w_end_y ? '0 : w_prow_base + c_LOC_W'(SUB_W);
          if (w_end_y) begin
            w_vert_nxt      = w_end_v ? '0 : w_pv + c_VY_W'(1);
            w_vert_base_nxt = w_end_v ? '0 : w_pvert_base + c_IDX_W'(GRID_X);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_WAIT_SOF;
      r_sub_x     <= '0;
      r_hori      <= '0;
      r_sub_y     <= '0;
      r_vert      <= '0;
      r_row_base  <= '0;
      r_vert_base <= '0;
      bram_wea    <= '0;
      bram_addr   <= '0;
      bram_din    <= '0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sub_x     <= w_sub_x_nxt;
      r_hori      <= w_hori_nxt;
      r_sub_y     <= w_sub_y_nxt;
      r_vert      <= w_vert_nxt;
      r_row_base  <= w_row_base_nxt;
      r_vert_base <= w_vert_base_nxt;
      bram_wea    <= w_accept ? (c_N'(1) << w_idx) : '0;
      bram_addr   <= w_accept ? w_addr : '0;
      bram_din    <= w_accept ? pix_data : '0;
      frame_done  <= w_accept && w_last;
      sync_err    <= w_sync_err;
    end
  end

`ifdef GCBP_PINGPONG_EN
  // The bank flips only on a completed frame, never on an SOF restart.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bank <= 1'b0;
    end else if (w_accept && w_last) begin
      r_bank <= ~r_bank;
    end
  end
`endif

  assign busy = (r_state == S_ACTIVE);

endmodule
`default_nettype wire
